// File: rtl/saw_pkg.sv
// Shared constants for the stop-and-wait transmit path:
// state encoding, frame field offsets, default timing.
package saw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } saw_state_e;

  localparam int DW_DEF        = 8;
  localparam int BW_DEF        = DW_DEF + 2;
  localparam int SEQ_BIT       = BW_DEF - 1;
  localparam int PAR_BIT       = 0;
  localparam int TIMEOUT_DEF   = 16;
  localparam int MAX_RETRY_DEF = 3;

  function automatic int seq_bit(input int bw);
    return bw - 1;
  endfunction

endpackage

// File: rtl/saw_timeout_timer.sv
// Cycle timer with clear/enable and a terminal-count pulse
// at TIMEOUT-1; shared by the transmit and receive sides.
module saw_timeout_timer #(
  parameter int TIMEOUT = 16,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc = en && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = tc ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/saw_tx_ctrl.sv
// Stop-and-wait ARQ transmit controller.
// Define SAW_NAK_EN to retransmit on NAK as well as timeout.
module saw_tx_ctrl
  import saw_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int BW        = DW + 2,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF,
  parameter int CW        = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          tx_valid,
  output logic [BW-1:0] tx_frame,
  input  logic          tx_ready,
  input  logic          ack_valid,
  input  logic          ack_seq,
  input  logic          nak_valid,
  output logic          done,
  output logic          fail,
  output logic          busy,
  output logic [1:0]    retry_cnt
);

  saw_state_e    state_q, state_d;
  logic          seq_q, seq_d;
  logic [DW-1:0] data_q, data_d;
  logic [1:0]    retry_q, retry_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic          tmo_tc;
  logic          ack_hit;
  logic          nak_hit;

  saw_timeout_timer #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_timer (
    .clk  (clk),
    .rstn (rstn),
    .clr  (state_q != WAIT),
    .en   (state_q == WAIT),
    .tc   (tmo_tc)
  );

  assign ack_hit = ack_valid && (ack_seq == seq_q);

`ifdef SAW_NAK_EN
  assign nak_hit = nak_valid;
`else
  logic unused_nak;
  assign unused_nak = nak_valid;
  assign nak_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    data_d  = data_q;
    retry_d = retry_q;
    done_d  = 1'b0;
    fail_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          retry_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx_ready)
          state_d = WAIT;
      end
      WAIT: begin
        // A matching ACK beats both timeout and NAK.
        if (ack_hit) begin
          done_d  = 1'b1;
          seq_d   = ~seq_q;
          state_d = IDLE;
        end else if (tmo_tc || nak_hit) begin
          if (int'(retry_q) < MAX_RETRY) begin
            retry_d = retry_q + 2'd1;
            state_d = SEND;
          end else begin
            fail_d  = 1'b1;
            seq_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      seq_q   <= 1'b0;
      data_q  <= '0;
      retry_q <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      data_q  <= data_d;
      retry_q <= retry_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign tx_valid  = (state_q == SEND);
  assign tx_frame  = {seq_q, data_q, ^{seq_q, data_q}};
  assign done      = done_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_saw_tx_ctrl.sv
// Directed bench for saw_tx_ctrl with a cycle-level
// reference model checked on every falling edge.
module tb_saw_tx_ctrl;

  localparam int DW = 8;
  localparam int BW = 10;
  localparam int TMO = 16;
  localparam int MAXR = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          tx_valid;
  logic [BW-1:0] tx_frame;
  logic          tx_ready = 1'b0;
  logic          ack_valid = 1'b0;
  logic          ack_seq = 1'b0;
  logic          nak_valid = 1'b0;
  logic          done;
  logic          fail;
  logic          busy;
  logic [1:0]    retry_cnt;

  saw_tx_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .tx_valid  (tx_valid),
    .tx_frame  (tx_frame),
    .tx_ready  (tx_ready),
    .ack_valid (ack_valid),
    .ack_seq   (ack_seq),
    .nak_valid (nak_valid),
    .done      (done),
    .fail      (fail),
    .busy      (busy),
    .retry_cnt (retry_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] mkf(input bit s,
                                        input logic [DW-1:0] d);
    bit p;
    p = ($countones({s, d}) % 2) == 1;
    return {s, d, p};
  endfunction

  // Reference model: busy/sending flags plus a count of
  // completed WAIT cycles, retries and the link sequence bit.
  bit          m_busy, m_sending, m_done, m_fail, m_seq;
  int          m_waited, m_retries;
  logic [DW-1:0] m_data;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy = 0; m_sending = 0; m_done = 0; m_fail = 0;
      m_seq = 0; m_waited = 0; m_retries = 0; m_data = '0;
    end else begin
      bit match, expire;
      m_done = 0;
      m_fail = 0;
      if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1; m_sending = 1;
          m_data = in_data; m_retries = 0;
        end
      end else if (m_sending) begin
        if (tx_ready) begin
          m_sending = 0; m_waited = 0;
        end
      end else begin
        m_waited++;
        match  = ack_valid && (ack_seq == m_seq);
        expire = (m_waited == TMO);
`ifdef SAW_NAK_EN
        expire = expire || nak_valid;
`endif
        if (match) begin
          m_done = 1; m_seq = !m_seq; m_busy = 0;
        end else if (expire) begin
          if (m_retries < MAXR) begin
            m_retries++; m_sending = 1;
          end else begin
            m_fail = 1; m_seq = 0; m_busy = 0;
          end
        end
      end
    end
  end

  int n_tx = 0, n_done = 0, n_fail = 0;

  always @(negedge clk) begin
    if (rstn) begin
      chk("in_ready", in_ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("tx_valid", tx_valid, m_busy && m_sending);
      chk("done", done, m_done);
      chk("fail", fail, m_fail);
      chk("retry_cnt", retry_cnt, m_retries);
      if (m_busy && m_sending)
        chk("tx_frame", tx_frame, mkf(m_seq, m_data));
      chk("done_fail_excl", done && fail, 0);
    end
    if (tx_valid && tx_ready) n_tx++;
    if (done) n_done++;
    if (fail) n_fail++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, tx0, d0, f0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_frame", tx_frame, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_fail", {done, fail}, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    step();

    // Clean transfer
    tx_ready = 1'b1;
    d0 = n_done;
    accept(8'hA5);
    chk("clean_tx_valid", tx_valid, 1);
    chk("clean_frame", tx_frame, 10'h14A);
    step();
    step();
    step();
    ack_valid = 1'b1; ack_seq = 1'b0;
    step();
    ack_valid = 1'b0;
    chk("clean_done", done, 1);
    chk("clean_in_ready", in_ready, 1);
    step();
    chk("clean_done_once", n_done - d0, 1);

    // Timeout retransmit, seq now 1
    accept(8'h3C);
    chk("tmo_frame", tx_frame, 10'h279);
    step();
    cyc = 1;
    while (!tx_valid && cyc < 40) begin
      step();
      cyc++;
    end
    chk("tmo_cycle", cyc, 17);
    chk("tmo_frame_same", tx_frame, 10'h279);
    chk("tmo_retry", retry_cnt, 1);
    step();
    step();
    ack_valid = 1'b1; ack_seq = 1'b1;
    step();
    ack_valid = 1'b0;
    chk("tmo_done", done, 1);
    step();

    // Retry exhaustion, seq now 0
    tx0 = n_tx;
    f0  = n_fail;
    accept(8'h5A);
    cyc = 0;
    while (!fail && cyc < 200) begin
      step();
      cyc++;
    end
    chk("exh_fail", fail, 1);
    chk("exh_in_ready", in_ready, 1);
    chk("exh_retry", retry_cnt, 3);
    step();
    chk("exh_tx_count", n_tx - tx0, 4);
    chk("exh_fail_once", n_fail - f0, 1);

    // Link reset puts seq back to 0
    accept(8'h11);
    chk("exh_seq0_frame", tx_frame, 10'h022);
    step();
    ack_valid = 1'b1; ack_seq = 1'b0;
    step();
    ack_valid = 1'b0;
    chk("seq0_done", done, 1);
    step();

    // Duplicate ACK then matching ACK at timeout, seq 1
    tx0 = n_tx;
    accept(8'hC3);
    chk("dup_frame", tx_frame, 10'h387);
    step();
    cyc = 1;
    step(); step();
    cyc = 3;
    ack_valid = 1'b1; ack_seq = 1'b0;
    step();
    cyc++;
    ack_valid = 1'b0;
    chk("dup_ignored", busy, 1);
    while (cyc < 16) begin
      step();
      cyc++;
    end
    ack_valid = 1'b1; ack_seq = 1'b1;
    step();
    ack_valid = 1'b0;
    chk("dup_done", done, 1);
    chk("dup_no_retx", tx_valid, 0);
    chk("dup_retry", retry_cnt, 0);
    step();
    chk("dup_tx_count", n_tx - tx0, 1);

    // Channel backpressure, seq 0
    tx_ready = 1'b0;
    accept(8'h7E);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", tx_valid, 1);
      chk("bp_frame", tx_frame, 10'h0FC);
      step();
    end
    tx_ready = 1'b1;
    step();
    chk("bp_wait", {busy, tx_valid}, 2'b10);

    // Async reset mid-WAIT
    step(); step(); step();
    d0 = n_done;
    f0 = n_fail;
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_tx_valid", tx_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_frame", tx_frame, 0);
    chk("arst_retry", retry_cnt, 0);
    step();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("arst_no_pulse", {n_done - d0, n_fail - f0}, 0);

    // NAK handling, seq 0 after reset
    accept(8'h81);
    chk("nak_frame", tx_frame, 10'h102);
    step();
    step();
    nak_valid = 1'b1;
    step();
    nak_valid = 1'b0;
`ifdef SAW_NAK_EN
    chk("nak_retx", tx_valid, 1);
    chk("nak_retry", retry_cnt, 1);
    step();
`else
    chk("nak_ignored", {busy, tx_valid}, 2'b10);
    chk("nak_retry", retry_cnt, 0);
`endif
    ack_valid = 1'b1; ack_seq = 1'b0; nak_valid = 1'b1;
    step();
    ack_valid = 1'b0; nak_valid = 1'b0;
    chk("acknak_done", done, 1);
    chk("acknak_fail", fail, 0);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/saw_tx_ctrl.md
Name: saw_tx_ctrl

Overview:
Stop-and-wait ARQ transmit controller. Accepts one data word from upstream, frames it with an alternating sequence bit and a parity bit, and presents it to the channel. It then waits for a matching ACK and retransmits on timeout, or on NAK when that feature is enabled. After MAX_RETRY failed retransmissions it aborts. Sits between the frame source and the channel serializer in the SAW transmit path.

Parameters:
DW, 8, payload data width
BW, 10, frame width; fixed at DW+2 ({seq, data, parity})
TIMEOUT, 16, WAIT cycles without matching ACK before a retransmit; must be >=2
MAX_RETRY, 3, retransmissions allowed before abort; must be >=1
CW, $clog2(TIMEOUT+1), timer width

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
in_valid  in  1  upstream word valid
in_data  in  DW  upstream payload
in_ready  out  1  controller can accept a word
tx_valid  out  1  frame presented to channel
tx_frame  out  BW  {seq, data, parity}; parity = even parity over {seq, data}
tx_ready  in  1  channel accepts frame this cycle
ack_valid  in  1  ACK received
ack_seq  in  1  sequence bit carried by the ACK
nak_valid  in  1  NAK received (used only with SAW_NAK_EN)
done  out  1  one-cycle pulse: frame acknowledged
fail  out  1  one-cycle pulse: retries exhausted
busy  out  1  state != IDLE
retry_cnt  out  2  retransmissions of the current frame (saturates at MAX_RETRY)

Behaviour:
- Reset (rstn low, async): state IDLE, seq=0, data reg=0, timer=0, retry_cnt=0. Outputs at reset: tx_valid=0, tx_frame=0, done=0, fail=0, busy=0, in_ready=1.
- All outputs are registered or decoded directly from state.
- States: IDLE, SEND, WAIT.
- IDLE:
  - in_ready=1.
  - in_valid&in_ready → latch in_data, retry_cnt=0, go SEND.
  - tx_valid first asserts the cycle after acceptance.
- SEND:
  - tx_valid=1; tx_frame stays stable until accepted.
  - tx_ready → go WAIT, timer=0.
  - ACK/NAK seen in SEND are ignored.
- WAIT:
  - Timer increments each cycle.
  - ack_valid & ack_seq==seq → done=1 next cycle, seq toggles, go IDLE. in_ready is 1 in that same cycle.
  - ack_valid with a mismatched seq is treated as a duplicate: ignored, timer continues.
  - Timeout fires when timer==TIMEOUT-1 (the TIMEOUT-th WAIT cycle):
    - retry_cnt<MAX_RETRY → retry_cnt+1, go SEND with the same seq and data.
    - Otherwise → fail=1 next cycle, seq reset to 0 (link reset), go IDLE.
- Simultaneous events:
  - Matching ACK and timeout in the same cycle → ACK wins.
  - Matching ACK and NAK in the same cycle → ACK wins.
- Wrap-around: seq is a 1-bit toggle. The timer never passes TIMEOUT-1 because it is cleared on entering WAIT.
- Reset mid-operation: the in-flight frame is dropped silently (no done, no fail) and seq returns to 0.
- done and fail are never asserted together.

Optional Feature:
SAW_NAK_EN
- Defined: in WAIT, nak_valid (no matching ACK in the same cycle) is handled exactly like an immediate timeout. It consumes one retry, or triggers fail when retries are exhausted.
- Undefined: nak_valid is ignored; only the timeout causes retransmission.

Decomposition:
- Shared package saw_pkg: state encoding constants (IDLE=2'd0, SEND=2'd1, WAIT=2'd2), frame field offsets (SEQ_BIT=BW-1, PAR_BIT=0), and default TIMEOUT/MAX_RETRY values.
- One sub-module, saw_timeout_timer: clear, enable, and a terminal-count pulse at TIMEOUT-1. It is reusable by the receive side.

Test Plan:
- Clean transfer:
  - Stimulus: in_data=8'hA5, seq=0; tx_ready held 1; ACK seq=0 three cycles after the handshake.
  - Required: tx_frame=10'h14A (parity 0); done pulses once; seq becomes 1; next frame carries seq bit 1.
- Timeout retransmit:
  - Stimulus: no ACK for 16 WAIT cycles.
  - Required: tx_valid reasserts on cycle 17 with an identical frame; retry_cnt=1. ACK then gives done.
- Retry exhaustion:
  - Stimulus: no ACK ever.
  - Required: 1 original plus 3 retransmissions; fail pulses one cycle after the 4th timeout; seq=0; in_ready=1.
- Duplicate ACK:
  - Stimulus: in WAIT with seq=1, ACK seq=0 arrives, followed by ACK seq=1 at the same cycle as the timeout.
  - Required: first ACK ignored; second yields done with no retransmit.
- Channel backpressure:
  - Stimulus: tx_ready low for 5 cycles in SEND.
  - Required: tx_frame stable; timer not running; WAIT entered only after tx_ready.
- Async reset in WAIT:
  - Stimulus: rstn pulled low mid-cycle.
  - Required: outputs take reset values immediately; no done or fail pulse.
  - With SAW_NAK_EN: nak_valid in WAIT triggers retransmit the next cycle with retry_cnt=1.
